// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter sharing one divider among N_REQ requesters.
// Captures operands on grant, runs the divider trigger/done handshake and returns
// q/r tagged with the requester id. Divide-by-zero is answered without using the divider.
// Optional watchdog on ISSUE/WAIT: define DIV_ARB_TIMEOUT_EN (limit TIMEOUT_CYC cycles).
module div_arbiter #(
    parameter int C_WIDTH     = 32,
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     ctl_clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*C_WIDTH-1:0] req_a,
    input  logic [N_REQ*C_WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]         req_signed,
    output logic [N_REQ-1:0]         req_ack,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [C_WIDTH-1:0]       rsp_q,
    output logic [C_WIDTH-1:0]       rsp_r,
    output logic                     rsp_err,
    output logic [C_WIDTH-1:0]       div_a,
    output logic [C_WIDTH-1:0]       div_b,
    output logic                     div_signed,
    output logic                     div_trigger,
    input  logic                     div_ready,
    input  logic                     div_done,
    input  logic [C_WIDTH-1:0]       div_q,
    input  logic [C_WIDTH-1:0]       div_r
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               trig_q, trig_d;
    logic               done_prev_q;
    logic [C_WIDTH-1:0] div_a_q, div_a_d;
    logic [C_WIDTH-1:0] div_b_q, div_b_d;
    logic               div_sgn_q, div_sgn_d;
    logic [ID_W-1:0]    res_id_q, res_id_d;
    logic [C_WIDTH-1:0] res_q_q, res_q_d;
    logic [C_WIDTH-1:0] res_r_q, res_r_d;
    logic               res_err_q, res_err_d;

    logic               gnt_found;
    logic [ID_W-1:0]    gnt_idx;
    logic [C_WIDTH-1:0] gnt_a, gnt_b;
    logic               gnt_sgn;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Round-robin search: first request at/after rr_q, otherwise the lowest one below it.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_a     = '0;
        gnt_b     = '0;
        gnt_sgn   = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!gnt_found && req_valid[i] && (i >= 32'(rr_q))) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(i);
                gnt_a     = req_a[i*C_WIDTH +: C_WIDTH];
                gnt_b     = req_b[i*C_WIDTH +: C_WIDTH];
                gnt_sgn   = req_signed[i];
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!gnt_found && req_valid[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(i);
                gnt_a     = req_a[i*C_WIDTH +: C_WIDTH];
                gnt_b     = req_b[i*C_WIDTH +: C_WIDTH];
                gnt_sgn   = req_signed[i];
            end
        end
    end

    // Transaction FSM: grant/capture, trigger on ready, wait for done rising edge, respond.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        id_d      = id_q;
        ack_d     = '0;
        trig_d    = 1'b0;
        div_a_d   = div_a_q;
        div_b_d   = div_b_q;
        div_sgn_d = div_sgn_q;
        res_id_d  = res_id_q;
        res_q_d   = res_q_q;
        res_r_d   = res_r_q;
        res_err_d = res_err_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    ack_d     = N_REQ'(1) << gnt_idx;
                    id_d      = gnt_idx;
                    div_a_d   = gnt_a;
                    div_b_d   = gnt_b;
                    div_sgn_d = gnt_sgn;
                    rr_d      = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
                    if (gnt_b == '0) begin
                        state_d   = S_RESP;
                        res_id_d  = gnt_idx;
                        res_q_d   = '1;
                        res_r_d   = gnt_a;
                        res_err_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (div_ready) begin
                    trig_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A done level still high from the previous op has no edge and is ignored.
                if (div_done && !done_prev_q) begin
                    state_d   = S_RESP;
                    res_id_d  = id_q;
                    res_q_d   = div_q;
                    res_r_d   = div_r;
                    res_err_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef DIV_ARB_TIMEOUT_EN
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if ((state_q == S_ISSUE || state_q == S_WAIT) && (state_d == state_q)) begin
            if (cnt_q >= CNT_W'(TIMEOUT_CYC - 1)) begin
                state_d   = S_RESP;
                res_id_d  = id_q;
                res_q_d   = '0;
                res_r_d   = '0;
                res_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    // State and datapath registers; reset clears every output-facing register.
    always_ff @(posedge ctl_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            ack_q       <= '0;
            trig_q      <= 1'b0;
            done_prev_q <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            div_sgn_q   <= 1'b0;
            res_id_q    <= '0;
            res_q_q     <= '0;
            res_r_q     <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            ack_q       <= ack_d;
            trig_q      <= trig_d;
            done_prev_q <= div_done;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            div_sgn_q   <= div_sgn_d;
            res_id_q    <= res_id_d;
            res_q_q     <= res_q_d;
            res_r_q     <= res_r_d;
            res_err_q   <= res_err_d;
        end
    end

`ifdef DIV_ARB_TIMEOUT_EN
    // Watchdog counter for the ISSUE/WAIT phases.
    always_ff @(posedge ctl_clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign req_ack     = ack_q;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_id      = res_id_q;
    assign rsp_q       = res_q_q;
    assign rsp_r       = res_r_q;
    assign rsp_err     = res_err_q;
    assign div_a       = div_a_q;
    assign div_b       = div_b_q;
    assign div_signed  = div_sgn_q;
    assign div_trigger = trig_q;

endmodule
